bemf_integrator_mc: RTL

Multi-channel, parametrised back-EMF integrator for the motor block. It takes time-multiplexed high-side and low-side ADC samples tagged with a channel number. Per channel it forms (high − low − calibration) and accumulates the result into an internal per-channel accumulator, with optional saturation. Per-channel calibration registers, per-channel clear and an overflow flag are held inside the block, so the caller no longer supplies the running value.

---
 rtl/bemf_integrator_mc.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bemf_integrator_mc.sv
`default_nettype none
// ============================================================================
// Module   : bemf_integrator_mc
// Brief    : Multi-channel back-EMF integrator. Per-channel calibration,
//            clear and accumulator storage with optional saturation.
// Revision : 1.0 - initial release
// ============================================================================
module bemf_integrator_mc #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int ADC_W  = 10,
  parameter int ACC_W  = 16,
  parameter int SHIFT  = 0,
  parameter int SAT_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADC_W-1:0]        adc_h,
  input  logic [ADC_W-1:0]        adc_l,
  input  logic [CH_W-1:0]         ch_in,
  input  logic                    in_valid,
  input  logic                    calib_we,
  input  logic [CH_W-1:0]         calib_ch,
  input  logic signed [ACC_W-1:0] calib_data,
  input  logic                    clr_valid,
  input  logic [CH_W-1:0]         clr_ch,
  output logic signed [ACC_W-1:0] bemf_out,
  output logic [CH_W-1:0]         ch_out,
  output logic                    out_valid,
  output logic                    ovf_flag
);

  localparam logic [CH_W:0]        c_NUM_CH  = NUM_CH[CH_W:0];
  localparam logic [ACC_W-1:0]     c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]     c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-ADC_W-1:0] c_ZEXT  = '0;

  logic                    r_s0_vld, r_s1_vld, r_s2_vld, r_s3_vld;
  logic [ADC_W-1:0]        r_s0_h, r_s0_l;
  logic [CH_W-1:0]         r_s0_ch, r_s1_ch, r_s2_ch, r_s3_ch;
  logic signed [ACC_W-1:0] r_s1_diff, r_s1_cal, r_s2_sub, r_s3_cal;
  logic signed [ACC_W-1:0] r_acc   [NUM_CH];
  logic signed [ACC_W-1:0] r_calib [NUM_CH];

  logic                    w_in_ok;
  logic signed [ACC_W-1:0] w_diff, w_acc_cur, w_res;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_ovf, w_clr_hit;

  assign w_in_ok   = in_valid && ({1'b0, ch_in} < c_NUM_CH);
  assign w_diff    = {c_ZEXT, r_s0_h} - {c_ZEXT, r_s0_l};
  assign w_acc_cur = r_acc[r_s3_ch];
  assign w_sum     = {w_acc_cur[ACC_W-1], w_acc_cur} + {r_s3_cal[ACC_W-1], r_s3_cal};
  assign w_ovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  // A clear of the channel being written this cycle overrides the update.
  assign w_clr_hit = clr_valid && (clr_ch == r_s3_ch);

  generate
    if (SAT_EN != 0) begin : g_sat
      assign w_res = !w_ovf ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX);
    end else begin : g_wrap
      assign w_res = w_sum[ACC_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_vld  <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_s0_h    <= '0;
      r_s0_l    <= '0;
      r_s0_ch   <= '0;
      r_s1_ch   <= '0;
      r_s2_ch   <= '0;
      r_s3_ch   <= '0;
      r_s1_diff <= '0;
      r_s1_cal  <= '0;
      r_s2_sub  <= '0;
      r_s3_cal  <= '0;
    end else begin
      r_s0_vld  <= w_in_ok;
      r_s0_h    <= adc_h;
      r_s0_l    <= adc_l;
      r_s0_ch   <= ch_in;
      r_s1_vld  <= r_s0_vld;
      r_s1_ch   <= r_s0_ch;
      r_s1_diff <= w_diff;
      r_s1_cal  <= r_calib[r_s0_ch];
      r_s2_vld  <= r_s1_vld;
      r_s2_ch   <= r_s1_ch;
      r_s2_sub  <= r_s1_diff - r_s1_cal;
      r_s3_vld  <= r_s2_vld;
      r_s3_ch   <= r_s2_ch;
      r_s3_cal  <= r_s2_sub >>> SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i]   <= '0;
        r_calib[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_valid && (clr_ch == CH_W'(i))) begin
          r_acc[i] <= '0;
        end else if (r_s3_vld && (r_s3_ch == CH_W'(i))) begin
          r_acc[i] <= w_res;
        end
        if (calib_we && (calib_ch == CH_W'(i))) begin
          r_calib[i] <= calib_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bemf_out  <= '0;
      ch_out    <= '0;
      out_valid <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      out_valid <= r_s3_vld;
      if (r_s3_vld) begin
        ch_out   <= r_s3_ch;
        bemf_out <= w_clr_hit ? '0 : w_res;
        ovf_flag <= w_clr_hit ? 1'b0 : w_ovf;
      end
    end
  end

endmodule
`default_nettype wire
